// File: rtl/vedic_mul_4x4.sv
// Registered 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier, 8-bit product.
// Define VEDIC_PIPE_EN to register the partial products (2-cycle latency).
module vedic_mul_4x4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] c,
    output logic       out_valid
);

    // {carry, sum}
    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
    endfunction

    function automatic logic [3:0] cell2(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] m;
        logic [1:0] h;
        m = ha(x[1] & y[0], x[0] & y[1]);
        h = ha(x[1] & y[1], m[1]);
        return {h[1], h[0], m[0], x[0] & y[0]};
    endfunction

    function automatic logic [4:0] add4(input logic [3:0] x, input logic [3:0] y);
        logic [4:0] r;
        logic [1:0] t;
        t = ha(x[0], y[0]);
        r[0] = t[0];
        for (int i = 1; i < 4; i++) begin
            t = fa(x[i], y[i], t[1]);
            r[i] = t[0];
        end
        r[4] = t[1];
        return r;
    endfunction

    // Addend has only two live bits, so the upper ripple is half adders.
    function automatic logic [5:0] add5_2(input logic [4:0] x, input logic [1:0] y);
        logic [5:0] r;
        logic [1:0] t;
        t = ha(x[0], y[0]);
        r[0] = t[0];
        t = fa(x[1], y[1], t[1]);
        r[1] = t[0];
        for (int i = 2; i < 5; i++) begin
            t = ha(x[i], t[1]);
            r[i] = t[0];
        end
        r[5] = t[1];
        return r;
    endfunction

    function automatic logic [7:0] combine(
        input logic [3:0] q0,
        input logic [3:0] q1,
        input logic [3:0] q2,
        input logic [3:0] q3
    );
        logic [4:0] s1;
        logic [5:0] s2;
        logic [4:0] hi;
        s1 = add4(q1, q2);
        s2 = add5_2(s1, q0[3:2]);
        hi = add4(q3, s2[5:2]);
        return {hi[3:0], s2[1:0], q0[1:0]};
    endfunction

    logic [3:0] q0, q1, q2, q3;

    always_comb begin
        q0 = cell2(a[1:0], b[1:0]);
        q1 = cell2(a[3:2], b[1:0]);
        q2 = cell2(a[1:0], b[3:2]);
        q3 = cell2(a[3:2], b[3:2]);
    end

`ifdef VEDIC_PIPE_EN
    logic [3:0] q0_r, q1_r, q2_r, q3_r;
    logic       v_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_r      <= '0;
            q1_r      <= '0;
            q2_r      <= '0;
            q3_r      <= '0;
            v_r       <= 1'b0;
            c         <= '0;
            out_valid <= 1'b0;
        end else begin
            v_r       <= in_valid;
            out_valid <= v_r;
            if (in_valid) begin
                q0_r <= q0;
                q1_r <= q1;
                q2_r <= q2;
                q3_r <= q3;
            end
            if (v_r) c <= combine(q0_r, q1_r, q2_r, q3_r);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) c <= combine(q0, q1, q2, q3);
        end
    end
`endif

endmodule

// File: tb/tb_vedic_mul_4x4.sv
// Directed and exhaustive checks for vedic_mul_4x4 against a latency-delay model.
// Define VEDIC_PIPE_EN here as for the RTL to check the 2-cycle build.
module tb_vedic_mul_4x4;

`ifdef VEDIC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a, b;
    logic [7:0] c;
    logic       out_valid;

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] pend [LAT];
    logic [7:0] mc;
    logic       mv;
    logic       cur_v;
    logic [7:0] cur_e;

    vedic_mul_4x4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c        (c),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < LAT; i++) pend[i] = '0;
        mc = '0;
        mv = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y,
                         input logic [7:0] e);
        in_valid = v;
        a        = x;
        b        = y;
        cur_v    = v;
        cur_e    = e;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
        end else begin
            for (int i = LAT - 1; i > 0; i--) pend[i] = pend[i-1];
            pend[0] = {cur_v, cur_e};
            mv = pend[LAT-1][8];
            if (mv) mc = pend[LAT-1][7:0];
        end
        @(negedge clk);
        check({tag, "_c"}, c, mc);
        check({tag, "_v"}, {7'b0, out_valid}, {7'b0, mv});
    endtask

    logic [3:0] da [5] = '{4'd0, 4'd12, 4'd13, 4'd10, 4'd15};
    logic [3:0] db [5] = '{4'd0, 4'd12, 4'd13, 4'd11, 4'd11};
    logic [7:0] de [5] = '{8'h00, 8'h90, 8'hA9, 8'h6E, 8'hA5};

    initial begin
        clear_model();
        rst_n = 1'b0;
        drive(1'b1, 4'd15, 4'd15, 8'hE1);
        #2;
        check("rst_async_c", c, 8'h00);
        check("rst_async_v", {7'b0, out_valid}, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 3; i++) step("rst_hold");

        rst_n = 1'b1;
        step("rst_rel");
        drive(1'b0, 4'd0, 4'd0, 8'h00);
        for (int i = 0; i < LAT + 1; i++) step("rst_rel");
        check("rst_rel_final", c, 8'hE1);

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, da[i], db[i], de[i]);
            step("dir");
        end
        drive(1'b0, 4'd0, 4'd0, 8'h00);
        for (int i = 0; i < LAT + 1; i++) step("dir_drain");
        check("dir_last", c, 8'hA5);

        drive(1'b1, 4'd7, 4'd9, 8'h3F);
        step("hold");
        for (int i = 0; i < 5 + LAT; i++) begin
            drive(1'b0, 4'($urandom), 4'($urandom), 8'h00);
            step("hold");
        end

        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 4'(i >> 4), 4'(i), 8'((i >> 4) * (i & 15)));
            step("exh");
        end
        drive(1'b0, 4'd0, 4'd0, 8'h00);
        for (int i = 0; i < LAT + 1; i++) step("exh_drain");
        check("exh_last", c, 8'hE1);

        drive(1'b1, 4'd9, 4'd9, 8'h51);
        step("mid");
        drive(1'b1, 4'd14, 4'd13, 8'hB6);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_c", c, 8'h00);
        check("mid_rst_v", {7'b0, out_valid}, 8'h00);
        clear_model();
        @(negedge clk);
        drive(1'b0, 4'd3, 4'd3, 8'h00);
        step("mid_low");
        step("mid_low");
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) step("mid_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vedic_mul_4x4.md
# vedic_mul_4x4

Registered 4x4-bit unsigned multiplier built on the Urdhva-Tiryagbhyam (vertical-and-crosswise) Vedic structure. Four 2x2 Vedic sub-multipliers produce partial products, which explicit adders combine into an exact 8-bit product. The block is a small arithmetic leaf for datapaths that need a low-depth, fixed-latency small multiply, with a valid strobe for pipelining.

## Interface
- No parameters. Widths are fixed at 4x4 -> 8.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies a and b on this cycle.
- a  input  4  multiplicand, unsigned.
- b  input  4  multiplier, unsigned.
- c  output  8  registered product a*b, unsigned.
- out_valid  output  1  high for exactly one cycle per accepted operand pair, aligned with c.

## Operation
- Split the operands: aL=a[1:0], aH=a[3:2], bL=b[1:0], bH=b[3:2].
- 2x2 Vedic cell (x, y -> 4 bits):
  - p0 = x0&y0
  - p1 = (x1&y0) ^ (x0&y1), with carry k = (x1&y0)&(x0&y1)
  - p2 = (x1&y1) ^ k
  - p3 = (x1&y1) & k
- Four cells: q0=aL*bL, q1=aH*bL, q2=aL*bH, q3=aH*bH.
- Combination:
  - c[1:0] = q0[1:0]
  - s1 = q1 + q2 (5 bits)
  - s2 = s1 + {2'b00, q0[3:2]} (6 bits)
  - c[3:2] = s2[1:0]
  - c[7:4] = q3 + s2[5:2], truncated to 4 bits. It cannot overflow; the maximum is 15*15=225.
- Build all adders from half and full adders. The result must equal the exact unsigned product for all 256 input pairs.
- Output register:
  - On a clock edge with in_valid=1, c loads the product and out_valid<=1.
  - With in_valid=0, c holds its previous value and out_valid<=0.
- No backpressure. Every in_valid cycle is accepted, and back-to-back operands give back-to-back results.

## Timing
- Reset (rst_n low, asynchronous and immediate): c=8'h00, out_valid=0. Both stay at these values while rst_n is low.
- Reset release is synchronous in effect: the first capture happens on the first rising edge with rst_n high.
- Latency, without VEDIC_PIPE_EN: 1 cycle. Operands sampled at edge N appear on c/out_valid after edge N.
- Latency, with VEDIC_PIPE_EN: 2 cycles.
- Throughput: one product per cycle in both configurations.
- Reset asserted mid-operation: all in-flight results are discarded, including the pipeline stage. No out_valid pulse follows for operands accepted before reset.
- Operands are don't-care when in_valid=0. X on a or b with in_valid=0 must not corrupt c.

## Configuration
- VEDIC_PIPE_EN:
  - Defined: q0..q3 and a valid bit are registered between the partial-product stage and the adder stage, and the final sum is registered again. Latency is 2 cycles. Pipeline registers reset to 0.
  - Undefined: the partial products and adders are purely combinational into the single output register. Latency is 1 cycle.
  - Arithmetic results are identical in both builds.

## Test plan
- Reset: hold rst_n=0 with a=15, b=15, in_valid=1 -> c=0x00, out_valid=0 throughout. Release -> c=0xE1 (225) after the configured latency.
- Directed sequence, one per cycle with in_valid=1: (0,0), (12,12), (13,13), (10,11), (15,11) -> c = 0x00, 0x90 (144), 0xA9 (169), 0x6E (110), 0xA5 (165) on consecutive out_valid cycles.
- Hold: one product, then in_valid=0 for 5 cycles with random a/b -> c is stable and out_valid=0.
- Exhaustive: all 256 (a,b) pairs back-to-back -> each c equals a*b at the correct latency, with out_valid continuously high.
- Mid-stream reset: assert rst_n=0 asynchronously (between edges) while results are in flight -> c=0 and out_valid=0 immediately, and no stale result appears after release.
- Build both with and without VEDIC_PIPE_EN -> latency of 2 and 1 respectively, and identical product streams.
